// File: rtl/alu16_seq_pkg.sv
// Shared types and constants for the alu16_sequencer front end and its register file.
package alu16_seq_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int FLAG_W = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OPRD = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } seq_state_t;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_INC = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;

    // Bit positions inside the {N,L,Z,C,F} flags vector.
    localparam int FLG_F = 0;
    localparam int FLG_C = 1;
    localparam int FLG_Z = 2;
    localparam int FLG_L = 3;
    localparam int FLG_N = 4;

    function automatic logic [FLAG_W-1:0] pack_flags(input logic n, input logic l,
                                                     input logic z, input logic c,
                                                     input logic f);
        logic [FLAG_W-1:0] v;
        v        = '0;
        v[FLG_N] = n;
        v[FLG_L] = l;
        v[FLG_Z] = z;
        v[FLG_C] = c;
        v[FLG_F] = f;
        return v;
    endfunction

endpackage

// File: rtl/regfile16x16.sv
// 16x16 register file: two operand read ports, one debug read port, one write port.
// With ALU16_SEQ_R0_ZERO_EN defined, r0 reads as zero and ignores writes.
module regfile16x16
    import alu16_seq_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              wr_ok;

`ifdef ALU16_SEQ_R0_ZERO_EN
    assign wr_ok    = (wr_addr != '0);
    assign ra_data  = (ra_addr  == '0) ? '0 : mem_q[ra_addr];
    assign rb_data  = (rb_addr  == '0) ? '0 : mem_q[rb_addr];
    assign dbg_data = (dbg_addr == '0) ? '0 : mem_q[dbg_addr];
`else
    assign wr_ok    = 1'b1;
    assign ra_data  = mem_q[ra_addr];
    assign rb_data  = mem_q[rb_addr];
    assign dbg_data = mem_q[dbg_addr];
`endif

    always_comb begin
        mem_d = mem_q;
        if (wr_en && wr_ok) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/alu16_sequencer.sv
// Command-driven front end for the external combinational ALU16: IDLE -> OPRD -> EXEC -> WB.
// Optional ALU16_SEQ_R0_ZERO_EN makes r0 a hard-wired zero register.
module alu16_sequencer
    import alu16_seq_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_load,
    input  logic [3:0]        cmd_sel,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [ADDR_W-1:0] cmd_ra,
    input  logic [ADDR_W-1:0] cmd_rb,
    input  logic [DATA_W-1:0] cmd_imm,
    input  logic              cmd_setf,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_n,
    input  logic              alu_l,
    input  logic              alu_z,
    input  logic              alu_c,
    input  logic              alu_f,
    output logic              done,
    output logic [FLAG_W-1:0] flags,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    seq_state_t        state_q, state_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              load_q, load_d;
    logic              setf_q, setf_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [ADDR_W-1:0] ra_q, ra_d;
    logic [ADDR_W-1:0] rb_q, rb_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [3:0]        alu_sel_q, alu_sel_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [FLAG_W-1:0] res_flags_q, res_flags_d;
    logic [FLAG_W-1:0] flags_q, flags_d;

    logic [DATA_W-1:0] ra_data, rb_data;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;

    assign wr_en   = (state_q == S_WB);
    assign wr_data = load_q ? imm_q : res_q;

    regfile16x16 #(
        .DEPTH (DEPTH)
    ) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra_addr  (ra_q),
        .ra_data  (ra_data),
        .rb_addr  (rb_q),
        .rb_data  (rb_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .wr_en    (wr_en),
        .wr_addr  (rd_q),
        .wr_data  (wr_data)
    );

    always_comb begin
        state_d     = state_q;
        ready_d     = ready_q;
        done_d      = done_q;
        load_d      = load_q;
        setf_d      = setf_q;
        rd_d        = rd_q;
        ra_d        = ra_q;
        rb_d        = rb_q;
        imm_d       = imm_q;
        alu_sel_d   = alu_sel_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        res_d       = res_q;
        res_flags_d = res_flags_q;
        flags_d     = flags_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && ready_q) begin
                    load_d    = cmd_load;
                    setf_d    = cmd_setf;
                    rd_d      = cmd_rd;
                    ra_d      = cmd_ra;
                    rb_d      = cmd_rb;
                    imm_d     = cmd_imm;
                    alu_sel_d = cmd_sel;
                    ready_d   = 1'b0;
                    // Loads skip the ALU entirely and write back on the next cycle.
                    if (cmd_load) begin
                        state_d = S_WB;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_OPRD;
                    end
                end
            end
            S_OPRD: begin
                opa_d   = ra_data;
                opb_d   = rb_data;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                res_d       = alu_out;
                res_flags_d = pack_flags(alu_n, alu_l, alu_z, alu_c, alu_f);
                done_d      = 1'b1;
                state_d     = S_WB;
            end
            S_WB: begin
                if (setf_q && !load_q) begin
                    flags_d = res_flags_q;
                end
                done_d    = 1'b0;
                ready_d   = 1'b1;
                alu_sel_d = '0;
                state_d   = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                ready_d   = 1'b1;
                done_d    = 1'b0;
                alu_sel_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            load_q      <= 1'b0;
            setf_q      <= 1'b0;
            rd_q        <= '0;
            ra_q        <= '0;
            rb_q        <= '0;
            imm_q       <= '0;
            alu_sel_q   <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            res_q       <= '0;
            res_flags_q <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            load_q      <= load_d;
            setf_q      <= setf_d;
            rd_q        <= rd_d;
            ra_q        <= ra_d;
            rb_q        <= rb_d;
            imm_q       <= imm_d;
            alu_sel_q   <= alu_sel_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            res_q       <= res_d;
            res_flags_q <= res_flags_d;
            flags_q     <= flags_d;
        end
    end

    assign cmd_ready = ready_q;
    assign done      = done_q;
    assign flags     = flags_q;
    assign alu_a     = opa_q;
    assign alu_b     = opb_q;
    assign alu_sel   = alu_sel_q;

endmodule

// File: tb/tb_alu16_sequencer.sv
// Directed bench for alu16_sequencer with a small behavioural ALU16 model on the alu_* ports.
module tb_alu16_sequencer;
    import alu16_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_load, cmd_setf;
    logic [3:0]  cmd_sel, cmd_rd, cmd_ra, cmd_rb;
    logic [15:0] cmd_imm;
    logic [15:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_sel;
    logic        alu_n, alu_l, alu_z, alu_c, alu_f;
    logic        done;
    logic [4:0]  flags;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu16_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
        .cmd_sel(cmd_sel), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
        .cmd_imm(cmd_imm), .cmd_setf(cmd_setf),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .alu_n(alu_n), .alu_l(alu_l), .alu_z(alu_z), .alu_c(alu_c), .alu_f(alu_f),
        .done(done), .flags(flags), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // ALU16 stand-in: ADD, SUB (a + ~b + 1, C = no borrow), INC; F = signed overflow.
    logic [16:0] sum;
    always_comb begin
        sum   = {1'b0, alu_a};
        alu_f = 1'b0;
        case (alu_sel)
            OP_ADD: begin
                sum   = {1'b0, alu_a} + {1'b0, alu_b};
                alu_f = (alu_a[15] == alu_b[15]) && (sum[15] != alu_a[15]);
            end
            OP_SUB: begin
                sum   = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
                alu_f = (alu_a[15] != alu_b[15]) && (sum[15] != alu_a[15]);
            end
            OP_INC: begin
                sum   = {1'b0, alu_a} + 17'd1;
                alu_f = !alu_a[15] && sum[15];
            end
            default: sum = {1'b0, alu_a};
        endcase
        alu_out = sum[15:0];
        alu_c   = sum[16];
        alu_n   = sum[15];
        alu_z   = (sum[15:0] == 16'h0000);
        alu_l   = ($signed(alu_a) < $signed(alu_b));
    end

    typedef struct {
        logic        load;
        logic [3:0]  sel;
        logic [3:0]  rd;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [15:0] imm;
        logic        setf;
        logic [15:0] exp_val;
        logic [4:0]  exp_flags;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        cmd_load = v.load;
        cmd_sel  = v.sel;
        cmd_rd   = v.rd;
        cmd_ra   = v.ra;
        cmd_rb   = v.rb;
        cmd_imm  = v.imm;
        cmd_setf = v.setf;
    endtask

    // Presents one command, returns the number of cycles from accept to the done pulse (-1 = none).
    task automatic run_cmd(input vec_t v, output int lat);
        int n;
        @(negedge clk);
        drive(v);
        cmd_valid = 1'b1;
        dbg_addr  = v.rd;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        int   lowcnt;
        logic seen_done;
        vec_t v;

        //              load sel      rd     ra     rb     imm       setf  exp_val   exp_flags
        tbl[0] = '{1'b1, 4'h0,   4'd1,  4'd0,  4'd0,  16'h7FFF, 1'b0, 16'h7FFF, 5'b00000};
        tbl[1] = '{1'b1, 4'h0,   4'd2,  4'd0,  4'd0,  16'h0001, 1'b0, 16'h0001, 5'b00000};
        tbl[2] = '{1'b0, OP_ADD, 4'd3,  4'd1,  4'd2,  16'h0000, 1'b1, 16'h8000, 5'b10001};
        tbl[3] = '{1'b0, OP_SUB, 4'd4,  4'd2,  4'd2,  16'h0000, 1'b1, 16'h0000, 5'b00110};
        tbl[4] = '{1'b0, OP_ADD, 4'd6,  4'd1,  4'd1,  16'h0000, 1'b0, 16'hFFFE, 5'b00110};
        tbl[5] = '{1'b0, OP_INC, 4'd7,  4'd3,  4'd0,  16'h0000, 1'b1, 16'h8001, 5'b11000};
        tbl[6] = '{1'b0, OP_SUB, 4'd1,  4'd1,  4'd2,  16'h0000, 1'b1, 16'h7FFE, 5'b00010};
        tbl[7] = '{1'b1, 4'h0,   4'd8,  4'd0,  4'd0,  16'h1234, 1'b0, 16'h1234, 5'b00010};
        tbl[8] = '{1'b0, OP_SUB, 4'd9,  4'd2,  4'd1,  16'h0000, 1'b1, 16'h8003, 5'b11000};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_load  = 1'b0;
        cmd_sel   = '0;
        cmd_rd    = '0;
        cmd_ra    = '0;
        cmd_rb    = '0;
        cmd_imm   = '0;
        cmd_setf  = 1'b0;
        dbg_addr  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int a = 0; a < 16; a++) begin
            dbg_addr = a[3:0];
            #1 check($sformatf("reset_r%0d", a), dbg_data, 16'h0000);
        end
        check("reset_flags", flags, 5'b00000);
        check("reset_ready", cmd_ready, 1'b1);
        check("reset_done", done, 1'b0);
        check("reset_alu_sel", alu_sel, 4'h0);
        check("reset_alu_a", alu_a, 16'h0000);

        for (int i = 0; i < 9; i++) begin
            run_cmd(tbl[i], lat);
            check($sformatf("v%0d_latency", i), lat, tbl[i].load ? 1 : 3);
            @(negedge clk);
            check($sformatf("v%0d_result", i), dbg_data, tbl[i].exp_val);
            check($sformatf("v%0d_flags", i), flags, tbl[i].exp_flags);
            check($sformatf("v%0d_ready", i), cmd_ready, 1'b1);
            check($sformatf("v%0d_done_low", i), done, 1'b0);
        end

        // Back-to-back ALU commands with cmd_valid held high; the second reads the first's result.
        @(negedge clk);
        v = '{1'b0, OP_ADD, 4'd10, 4'd2, 4'd2, 16'h0000, 1'b0, 16'h0002, 5'b11000};
        drive(v);
        cmd_valid = 1'b1;
        check("b2b_ready_before", cmd_ready, 1'b1);
        lowcnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!cmd_ready) lowcnt++;
            else break;
        end
        check("b2b_ready_low_cycles", lowcnt, 3);
        v = '{1'b0, OP_ADD, 4'd11, 4'd10, 4'd2, 16'h0000, 1'b0, 16'h0003, 5'b11000};
        drive(v);
        dbg_addr = 4'd11;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        check("b2b_second_latency", lat, 3);
        check("wb_dbg_old_value", dbg_data, 16'h0000);
        @(negedge clk);
        check("b2b_second_result", dbg_data, 16'h0003);
        dbg_addr = 4'd10;
        #1 check("b2b_first_result", dbg_data, 16'h0002);

        // Reset pulse during EXEC of ADD r5 = r1 + r2 aborts the command.
        @(negedge clk);
        v = '{1'b0, OP_ADD, 4'd5, 4'd1, 4'd2, 16'h0000, 1'b1, 16'h7FFF, 5'b00000};
        drive(v);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("exec_alu_a", alu_a, 16'h7FFE);
        check("exec_alu_b", alu_b, 16'h0001);
        check("exec_alu_sel", alu_sel, OP_ADD);
        rst_n = 1'b0;
        #1;
        check("abort_ready", cmd_ready, 1'b1);
        check("abort_done", done, 1'b0);
        seen_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen_done = seen_done | done;
        end
        check("abort_no_done", seen_done, 1'b0);
        dbg_addr = 4'd5;
        #1 check("abort_r5", dbg_data, 16'h0000);
        dbg_addr = 4'd1;
        #1 check("abort_r1_cleared", dbg_data, 16'h0000);
        check("abort_flags", flags, 5'b00000);
        check("abort_alu_sel", alu_sel, 4'h0);
        check("abort_idle_ready", cmd_ready, 1'b1);

        // r0 behaviour depends on the zero-register build option.
        v = '{1'b1, 4'h0, 4'd0, 4'd0, 4'd0, 16'hFFFF, 1'b1, 16'h0000, 5'b00000};
        run_cmd(v, lat);
        check("r0_load_latency", lat, 1);
        @(negedge clk);
        dbg_addr = 4'd0;
`ifdef ALU16_SEQ_R0_ZERO_EN
        #1 check("r0_read", dbg_data, 16'h0000);
`else
        #1 check("r0_read", dbg_data, 16'hFFFF);
`endif
        check("r0_load_flags", flags, 5'b00000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
